// File: rtl/bft_client_port.sv
// Leaf client port of the BFT: buffers injections, ejects local packets and re-injects bounced traffic ahead of the FIFO.
// Fully registered link and client outputs with 2-edge injection latency; cli_i_rdy drops while the FIFO is full.
module bft_client_port #(
  parameter int N          = 8,
  parameter int A_W        = $clog2(N) + 1,
  parameter int D_W        = 32,
  parameter int posx       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           cli_i_v,
  input  logic [A_W-1:0] cli_i_addr,
  input  logic [D_W-1:0] cli_i_data,
  output logic           cli_i_rdy,
  output logic           cli_o_v,
  output logic [D_W-1:0] cli_o_data,
  input  logic           net_i_v,
  input  logic           net_i_defl,
  input  logic [A_W-1:0] net_i_addr,
  input  logic [D_W-1:0] net_i_data,
  output logic           net_o_v,
  output logic           net_o_defl,
  output logic [A_W-1:0] net_o_addr,
  output logic [D_W-1:0] net_o_data,
  output logic [15:0]    defl_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [A_W-1:0]   MY_ADDR  = A_W'(posx);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [A_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [D_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             net_v_q, net_v_d;
  logic [A_W-1:0]   net_addr_q, net_addr_d;
  logic [D_W-1:0]   net_data_q, net_data_d;
  logic             cli_v_q, cli_v_d;
  logic [D_W-1:0]   cli_data_q, cli_data_d;
  logic [15:0]      defl_cnt_q, defl_cnt_d;

  logic             full, empty;
  logic             eject, bounce;
  logic [A_W-1:0]   head_addr;
  logic [D_W-1:0]   head_data;
  logic             head_local;
  logic             push, pop;

  // Deflected and fresh arrivals are classified identically, by address only.
  logic unused_defl;
  assign unused_defl = net_i_defl;

  assign full       = (cnt_q == FULL_CNT);
  assign empty      = (cnt_q == '0);
  assign cli_i_rdy  = rst & ~full;

  assign eject      = net_i_v & (net_i_addr == MY_ADDR);
  assign bounce     = net_i_v & (net_i_addr != MY_ADDR);

  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_local = (head_addr == MY_ADDR);

  assign push = ce & cli_i_v & cli_i_rdy;
  // A self-addressed head waits while the client output is taken by an ejection.
  assign pop  = ce & ~bounce & ~empty & (~head_local | ~eject);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    net_v_d    = net_v_q;
    net_addr_d = net_addr_q;
    net_data_d = net_data_q;
    cli_v_d    = cli_v_q;
    cli_data_d = cli_data_q;
    defl_cnt_d = defl_cnt_q;
    if (ce) begin
      net_v_d = 1'b0;
      cli_v_d = 1'b0;
      if (bounce) begin
        net_v_d    = 1'b1;
        net_addr_d = net_i_addr;
        net_data_d = net_i_data;
        if (defl_cnt_q != 16'hFFFF) begin
          defl_cnt_d = defl_cnt_q + 16'd1;
        end
      end else if (pop && !head_local) begin
        net_v_d    = 1'b1;
        net_addr_d = head_addr;
        net_data_d = head_data;
      end
      if (eject) begin
        cli_v_d    = 1'b1;
        cli_data_d = net_i_data;
      end else if (pop && head_local) begin
        cli_v_d    = 1'b1;
        cli_data_d = head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (push) begin
      fifo_addr_q[wr_ptr_q] <= cli_i_addr;
      fifo_data_q[wr_ptr_q] <= cli_i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      net_v_q    <= 1'b0;
      net_addr_q <= '0;
      net_data_q <= '0;
      cli_v_q    <= 1'b0;
      cli_data_q <= '0;
      defl_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      net_v_q    <= net_v_d;
      net_addr_q <= net_addr_d;
      net_data_q <= net_data_d;
      cli_v_q    <= cli_v_d;
      cli_data_q <= cli_data_d;
      defl_cnt_q <= defl_cnt_d;
    end
  end

  assign net_o_v    = net_v_q;
  assign net_o_defl = 1'b0;
  assign net_o_addr = net_addr_q;
  assign net_o_data = net_data_q;
  assign cli_o_v    = cli_v_q;
  assign cli_o_data = cli_data_q;
  assign defl_cnt   = defl_cnt_q;

endmodule

// File: tb/tb_bft_client_port.sv
// Bench for bft_client_port with posx=3: vector table, scoreboard monitor and multi-cycle corner sequences.
module tb_bft_client_port;
  localparam int N = 8, A_W = 4, D_W = 32, POSX = 3, DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ce  = 1'b0;
  logic           cli_i_v = 1'b0;
  logic [A_W-1:0] cli_i_addr = '0;
  logic [D_W-1:0] cli_i_data = '0;
  logic           cli_i_rdy;
  logic           cli_o_v;
  logic [D_W-1:0] cli_o_data;
  logic           net_i_v = 1'b0;
  logic           net_i_defl = 1'b0;
  logic [A_W-1:0] net_i_addr = '0;
  logic [D_W-1:0] net_i_data = '0;
  logic           net_o_v;
  logic           net_o_defl;
  logic [A_W-1:0] net_o_addr;
  logic [D_W-1:0] net_o_data;
  logic [15:0]    defl_cnt;

  bft_client_port #(.N(N), .A_W(A_W), .D_W(D_W), .posx(POSX), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cli_i_v(cli_i_v), .cli_i_addr(cli_i_addr), .cli_i_data(cli_i_data), .cli_i_rdy(cli_i_rdy),
    .cli_o_v(cli_o_v), .cli_o_data(cli_o_data),
    .net_i_v(net_i_v), .net_i_defl(net_i_defl), .net_i_addr(net_i_addr), .net_i_data(net_i_data),
    .net_o_v(net_o_v), .net_o_defl(net_o_defl), .net_o_addr(net_o_addr), .net_o_data(net_o_data),
    .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [A_W+D_W-1:0] exp_net_q[$];
  logic [D_W-1:0]     exp_cli_q[$];
  logic [A_W+D_W-1:0] net_e;
  logic [D_W-1:0]     cli_e;
  logic               edge_live = 1'b0;

  typedef struct {
    logic           v;
    logic           defl;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
    logic           exp_cli_v;
    logic           exp_net_v;
    logic [15:0]    exp_cnt;
  } vec_t;
  vec_t vecs[7];
  logic [A_W-1:0] paddr[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_net();
    net_i_v = 1'b0; net_i_defl = 1'b0; net_i_addr = '0; net_i_data = '0;
  endtask

  task automatic drive_net(input logic defl, input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    net_i_v = 1'b1; net_i_defl = defl; net_i_addr = a; net_i_data = d;
  endtask

  // Outputs only count as produced after an edge that had ce high and reset released.
  always @(posedge clk) edge_live <= ce & rst;

  always @(negedge clk) begin
    if (edge_live) begin
      if (net_o_v) begin
        n_cmp++;
        if (exp_net_q.size() == 0) begin
          n_fail++;
          $display("FAIL net_unexpected: got addr %0h data %0h, none expected", net_o_addr, net_o_data);
        end else begin
          net_e = exp_net_q.pop_front();
          if ({net_o_addr, net_o_data} !== net_e || net_o_defl !== 1'b0) begin
            n_fail++;
            $display("FAIL net_sb: got %0h defl %0b expected %0h defl 0", {net_o_addr, net_o_data}, net_o_defl, net_e);
          end
        end
      end
      if (cli_o_v) begin
        n_cmp++;
        if (exp_cli_q.size() == 0) begin
          n_fail++;
          $display("FAIL cli_unexpected: got data %0h, none expected", cli_o_data);
        end else begin
          cli_e = exp_cli_q.pop_front();
          if (cli_o_data !== cli_e) begin
            n_fail++;
            $display("FAIL cli_sb: got %0h expected %0h", cli_o_data, cli_e);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd3,  32'h0000_1234, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 4'd3,  32'h0000_1234, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 4'd3,  32'hDEAD_BEEF, 1'b1, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 4'd11, 32'h0BAD_0B0B, 1'b0, 1'b1, 16'd1};
    vecs[5] = '{1'b1, 1'b1, 4'd0,  32'hCAFE_F00D, 1'b0, 1'b1, 16'd2};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 16'd2};
    paddr[0] = 4'd1; paddr[1] = 4'd2; paddr[2] = 4'd4; paddr[3] = 4'd5;

    // Reset with idle links.
    rst = 1'b0; ce = 1'b1; idle_net();
    repeat (3) tick();
    chk("rst_rdy", cli_i_rdy, 0);
    chk("rst_net_v", net_o_v, 0);
    chk("rst_net_defl", net_o_defl, 0);
    chk("rst_cli_v", cli_o_v, 0);
    chk("rst_cnt", defl_cnt, 0);
    rst = 1'b1;
    #1;
    chk("rdy_after_rst", cli_i_rdy, 1);

    // Plain injection: two-edge latency, single-cycle valid.
    cli_i_v = 1'b1; cli_i_addr = 4'd5; cli_i_data = 32'hA5A5_A5A5;
    exp_net_q.push_back({4'd5, 32'hA5A5_A5A5});
    tick();
    cli_i_v = 1'b0;
    chk("inj_no_fallthru", net_o_v, 0);
    tick();
    chk("inj_v", net_o_v, 1);
    chk("inj_addr", net_o_addr, 5);
    chk("inj_data", net_o_data, 32'hA5A5_A5A5);
    chk("inj_defl", net_o_defl, 0);
    tick();
    chk("inj_v_drop", net_o_v, 0);

    // Single-cycle eject/bounce vectors.
    for (int i = 0; i < 7; i++) begin
      net_i_v = vecs[i].v; net_i_defl = vecs[i].defl;
      net_i_addr = vecs[i].addr; net_i_data = vecs[i].data;
      if (vecs[i].exp_cli_v) exp_cli_q.push_back(vecs[i].data);
      if (vecs[i].exp_net_v) exp_net_q.push_back({vecs[i].addr, vecs[i].data});
      tick();
      chk($sformatf("vec%0d_cli_v", i), cli_o_v, vecs[i].exp_cli_v);
      chk($sformatf("vec%0d_net_v", i), net_o_v, vecs[i].exp_net_v);
      chk($sformatf("vec%0d_cnt", i), defl_cnt, vecs[i].exp_cnt);
    end
    idle_net();
    chk("tbl_drain", exp_net_q.size() + exp_cli_q.size(), 0);

    rst = 1'b0;
    tick();
    chk("mid_rst_cnt", defl_cnt, 0);
    chk("mid_rst_net_v", net_o_v, 0);
    rst = 1'b1;

    // Bounce overtakes a waiting FIFO head.
    cli_i_v = 1'b1; cli_i_addr = 4'd6; cli_i_data = 32'h6666_6666;
    tick();
    cli_i_v = 1'b0;
    drive_net(1'b0, 4'd2, 32'h77);
    exp_net_q.push_back({4'd2, 32'h77});
    exp_net_q.push_back({4'd6, 32'h6666_6666});
    tick();
    idle_net();
    chk("prio_bounce_v", net_o_v, 1);
    chk("prio_bounce_addr", net_o_addr, 2);
    chk("prio_bounce_data", net_o_data, 32'h77);
    chk("prio_cnt", defl_cnt, 1);
    tick();
    chk("prio_head_v", net_o_v, 1);
    chk("prio_head_addr", net_o_addr, 6);
    tick();
    chk("prio_idle", net_o_v, 0);

    // Fill the FIFO under continuous bounces, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive_net(1'b1, 4'd7, 32'hB0 + i);
      exp_net_q.push_back({4'd7, 32'hB0 + i});
      cli_i_v = 1'b1; cli_i_addr = paddr[i]; cli_i_data = 32'h100 + i;
      chk($sformatf("fill_rdy%0d", i), cli_i_rdy, 1);
      tick();
    end
    chk("full_rdy", cli_i_rdy, 0);
    for (int j = 0; j < 2; j++) begin
      drive_net(1'b0, 4'd7, 32'hB4 + j);
      exp_net_q.push_back({4'd7, 32'hB4 + j});
      cli_i_addr = 4'd1; cli_i_data = 32'hBAD;
      tick();
      chk($sformatf("full_hold_rdy%0d", j), cli_i_rdy, 0);
      chk($sformatf("full_bounce_addr%0d", j), net_o_addr, 7);
    end
    chk("fill_cnt", defl_cnt, 7);
    cli_i_v = 1'b0; idle_net();
    for (int i = 0; i < 4; i++) exp_net_q.push_back({paddr[i], 32'h100 + i});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain%0d_v", i), net_o_v, 1);
      chk($sformatf("drain%0d_addr", i), net_o_addr, paddr[i]);
      chk($sformatf("drain%0d_data", i), net_o_data, 32'h100 + i);
    end
    tick();
    chk("drain_done", net_o_v, 0);

    // Loopback blocked by an eject, then a ce freeze.
    cli_i_v = 1'b1; cli_i_addr = 4'd3; cli_i_data = 32'h55;
    tick();
    cli_i_v = 1'b0;
    drive_net(1'b0, 4'd3, 32'h66);
    exp_cli_q.push_back(32'h66);
    exp_cli_q.push_back(32'h55);
    tick();
    chk("lb_eject_v", cli_o_v, 1);
    chk("lb_eject_data", cli_o_data, 32'h66);
    ce = 1'b0;
    drive_net(1'b0, 4'd0, 32'hF00);
    cli_i_v = 1'b1; cli_i_addr = 4'd1; cli_i_data = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz%0d_cli_v", i), cli_o_v, 1);
      chk($sformatf("frz%0d_cli_data", i), cli_o_data, 32'h66);
      chk($sformatf("frz%0d_net_v", i), net_o_v, 0);
      chk($sformatf("frz%0d_cnt", i), defl_cnt, 7);
    end
    cli_i_v = 1'b0; idle_net(); ce = 1'b1;
    tick();
    chk("lb_v", cli_o_v, 1);
    chk("lb_data", cli_o_data, 32'h55);
    chk("lb_net_v", net_o_v, 0);
    tick();
    chk("lb_done", cli_o_v, 0);
    repeat (3) tick();
    chk("final_net_v", net_o_v, 0);
    chk("final_drain", exp_net_q.size() + exp_cli_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bft_client_port.md
Name: bft_client_port

Overview:
- Leaf-side client port of the deflection-routed BFT. It sits directly upstream of the level-0 T-switch route/mux stage and drives that switch's client-side input link.
- It buffers client injections in a small FIFO and ejects packets addressed to this client.
- Packets the switch bounces back to the client (deflections) are re-injected with priority, so the client never drops in-flight traffic.
- Link output is fully registered to meet the switch's one-cycle link timing.

Parameters:
- N, 8, number of clients
- A_W, $clog2(N)+1, address width
- D_W, 32, payload width
- posx, 0, this client's address
- FIFO_DEPTH, 4, injection FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- ce  in  1  clock enable shared with the switch
- cli_i_v  in  1  client injection valid
- cli_i_addr  in  A_W  injection destination
- cli_i_data  in  D_W  injection payload
- cli_i_rdy  out  1  injection ready
- cli_o_v  out  1  ejection valid, one-cycle pulse, no backpressure
- cli_o_data  out  D_W  ejected payload
- net_i_v  in  1  valid of packet arriving from switch
- net_i_defl  in  1  arriving packet flagged as deflected
- net_i_addr  in  A_W  arriving packet destination
- net_i_data  in  D_W  arriving payload
- net_o_v  out  1  valid toward switch client input
- net_o_defl  out  1  deflect flag toward switch; always 0
- net_o_addr  out  A_W  destination toward switch
- net_o_data  out  D_W  payload toward switch
- defl_cnt  out  16  saturating count of bounced packets

Behaviour:
- Reset: asynchronous on rst=0. Clears all registers, empties the FIFO and zeroes defl_cnt. net_o_v=0, net_o_defl=0, net_o_addr=0, net_o_data=0, cli_o_v=0, cli_o_data=0.
- cli_i_rdy = rst & ~full (combinational). It is low throughout reset.
- ce=0: no state change. Registered outputs hold their values. Handshakes do not complete.
- Each ce edge, classify net_i:
  - eject: net_i_v & (net_i_addr == posx), full A_W compare, regardless of net_i_defl.
  - bounce: net_i_v & (net_i_addr != posx).
- Eject: cli_o_v=1 and cli_o_data=net_i_data on the next edge. Otherwise cli_o_v=0.
- Bounce: the next edge registers the packet into net_o (v=1, addr and data unchanged, defl=0). defl_cnt increments, saturating at 0xFFFF. The FIFO does not pop that cycle.
- Injection push: cli_i_v & cli_i_rdy & ce. The packet enters the FIFO tail.
- Injection pop: when there is no bounce and the FIFO is non-empty.
  - Head addr != posx: head moves to net_o (v=1, defl=0).
  - Head addr == posx: local loopback. Head moves to cli_o, but only if no eject occurs this cycle; otherwise the head stays.
  - If nothing is sent to the network, net_o_v=0 on the next edge.
- No fall-through:
  - Earliest net_o_v is 2 ce edges after the accepting edge (accept edge k, net_o_v high after edge k+1).
  - Loopback has the same 2-edge latency on cli_o_v.
- Push and pop in the same cycle are allowed; occupancy is unchanged. Push while full is impossible because rdy=0.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- At most one network output and one client output per cycle. Priority for net_o: bounce > FIFO head.
- Reset asserted mid-stream discards buffered and in-flight packets; the bench must not expect them.

Test Plan:
- Reset release with idle links → net_o_v=0, cli_o_v=0, defl_cnt=0. cli_i_rdy=0 while rst=0 and 1 on the first cycle after release.
- posx=3. Inject addr=5, data=0xA5A5A5A5 at edge k → net_o_v=1, net_o_addr=5, net_o_defl=0 after edge k+1, then net_o_v=0.
- net_i_v=1, addr=3, data=0x1234 (defl=0, then repeat with defl=1) → cli_o_v=1, cli_o_data=0x1234 next edge each time.
- FIFO holds addr=6 and net_i bounce addr=2, data=0x77 arrives → next edge net_o_addr=2, defl_cnt=1. Addr=6 goes out the following edge.
- Fill 4 entries while net_i bounces every cycle → cli_i_rdy=0 after the 4th push, nothing pops. After bounces stop, 4 packets leave in order on consecutive edges.
- Inject self-addressed addr=3, data=0x55 while net_i ejects addr=3, data=0x66 → cli_o_data=0x66 first, 0x55 one edge later. ce=0 for 3 cycles in between freezes all outputs.
